// File: rtl/booth_divider.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per clock, sign correction applied in a final cycle.
module booth_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // CALC  | one restoring step per cycle, WIDTH cycles
  // FIN   | apply signs, publish results, pulse done
  // ZDIV  | divisor was zero; publish saturated quotient
  typedef enum logic [1:0] {IDLE, CALC, FIN, ZDIV} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             sgn_dd_q, sgn_dd_d;
  logic             sgn_ds_q, sgn_ds_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] abs_dd, abs_ds;
  logic [WIDTH:0]   shifted, trial;

  // |MIN| wraps to MIN, which reads correctly as unsigned 2^(WIDTH-1)
  assign abs_dd  = dividend[WIDTH-1] ? -dividend : dividend;
  assign abs_ds  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    sgn_dd_d    = sgn_dd_q;
    sgn_ds_d    = sgn_ds_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor == '0) begin
            state_d = ZDIV;
            rem_d   = dividend;
          end else begin
            state_d  = CALC;
            quo_d    = abs_dd;
            dsr_d    = abs_ds;
            rem_d    = '0;
            count_d  = '0;
            sgn_dd_d = dividend[WIDTH-1];
            sgn_ds_d = divisor[WIDTH-1];
          end
        end
      end
      CALC: begin
        quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        quotient_d  = (sgn_dd_q ^ sgn_ds_q) ? -quo_q : quo_q;
        remainder_d = sgn_dd_q ? -rem_q : rem_q;
        dbz_d       = 1'b0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      ZDIV: begin
        quotient_d  = '1;
        remainder_d = rem_q;
        dbz_d       = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      sgn_dd_q    <= 1'b0;
      sgn_ds_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      sgn_dd_q    <= sgn_dd_d;
      sgn_ds_q    <= sgn_ds_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed and random checks for booth_divider at WIDTH=32.
module tb_booth_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  booth_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // lat = negedges after accept edge E until done seen (done after E+lat), -1 on timeout
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output int lat, output int bcnt);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (busy) bcnt++;
    end
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b dz=%b q=%h r=%h want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] q, r; logic dz; int lat, bc;
    run_op(32'd100, 32'd7, q, r, dz, lat, bc);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", lat); end
    checks++;
    if (bc !== 33) begin errors++; $display("FAIL basic_busy_cycles got %0d want 33", bc); end
    checks++;
    if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin
      errors++; $display("FAIL basic_100_7 got q=%0d r=%0d dz=%b want 14 2 0", q, r, dz);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
  endtask

  task automatic test_signs();
    logic signed [31:0] a[5]  = '{-100, 100, -100, 0, 3};
    logic signed [31:0] b[5]  = '{7, -7, -7, 5, 5};
    logic signed [31:0] eq[5] = '{-14, -14, 14, 0, 0};
    logic signed [31:0] er[5] = '{-2, 2, -2, 0, 3};
    logic [31:0] q, r; logic dz; int lat, bc;
    for (int i = 0; i < 5; i++) begin
      run_op(a[i], b[i], q, r, dz, lat, bc);
      checks++;
      if (q !== eq[i] || r !== er[i] || lat !== 33) begin
        errors++;
        $display("FAIL sign_case_%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=33",
                 i, $signed(q), $signed(r), lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; logic dz; int lat, bc;
    run_op(32'd1234, 32'd0, q, r, dz, lat, bc);
    checks++;
    if (q !== 32'hFFFFFFFF || r !== 32'd1234 || dz !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL div_zero got q=%h r=%0d dz=%b lat=%0d want ffffffff 1234 1 1", q, r, dz, lat);
    end
    run_op(32'd9, 32'd3, q, r, dz, lat, bc);
    checks++;
    if (q !== 32'd3 || r !== 32'd0 || dz !== 1'b0) begin
      errors++; $display("FAIL after_zero got q=%0d r=%0d dz=%b want 3 0 0", q, r, dz);
    end
  endtask

  task automatic test_extremes();
    logic [31:0] a[3]  = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] b[3]  = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000};
    logic [31:0] eq[3] = '{32'h80000000, 32'h80000000, 32'h00000000};
    logic [31:0] er[3] = '{32'h00000000, 32'h00000000, 32'h7FFFFFFF};
    logic [31:0] q, r; logic dz; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(a[i], b[i], q, r, dz, lat, bc);
      checks++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
        errors++;
        $display("FAIL extreme_%0d got q=%h r=%h dz=%b want q=%h r=%h dz=0",
                 i, q, r, dz, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_protocol();
    int lat = -1, pulses = 0;
    @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 9) begin dividend = 32'd9; divisor = 32'd2; start = 1'b1; end
      if (k == 10) start = 1'b0;
      if (done) begin lat = k; pulses++; break; end
    end
    checks++;
    if (lat !== 33 || quotient !== 32'd10 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL protocol_ignore got q=%0d r=%0d lat=%0d want 10 0 33", quotient, remainder, lat);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL protocol_done_pulses got %0d want 1", pulses); end
    checks++;
    if (quotient !== 32'd10 || remainder !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL protocol_hold got q=%0d r=%0d busy=%b want 10 0 0", quotient, remainder, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = -1, lat2 = -1;
    logic [31:0] q1, r1;
    @(negedge clk);
    dividend = 32'd20; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 32) begin dividend = 32'd45; divisor = 32'd4; start = 1'b1; end
      if (done) begin lat1 = k; break; end
    end
    q1 = quotient; r1 = remainder;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin lat2 = k; break; end
    end
    checks++;
    if (lat1 !== 33 || q1 !== 32'd6 || r1 !== 32'd2) begin
      errors++; $display("FAIL b2b_first got q=%0d r=%0d lat=%0d want 6 2 33", q1, r1, lat1);
    end
    checks++;
    if (lat2 !== 33 || quotient !== 32'd11 || remainder !== 32'd1) begin
      errors++;
      $display("FAIL b2b_second got q=%0d r=%0d lat=%0d want 11 1 33", quotient, remainder, lat2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r; logic dz; int lat, bc;
    int spurious = 0;
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 14; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b dz=%b q=%h r=%h want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    repeat (3) begin @(negedge clk); if (done) spurious++; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done || busy) spurious++; end
    checks++;
    if (spurious !== 0) begin errors++; $display("FAIL reset_no_done got %0d active cycles want 0", spurious); end
    run_op(32'd81, 32'd9, q, r, dz, lat, bc);
    checks++;
    if (q !== 32'd9 || r !== 32'd0 || lat !== 33) begin
      errors++; $display("FAIL reset_recover got q=%0d r=%0d lat=%0d want 9 0 33", q, r, lat);
    end
  endtask

  task automatic test_random();
    logic signed [31:0] a, b, eq, er;
    logic [31:0] q, r; logic dz, edz; int lat, bc, sel;
    for (int n = 0; n < 1800; n++) begin
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = $signed($urandom_range(0, 16)) - 8;
      if (sel == 1) a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
      if (sel == 2) b = b >>> $urandom_range(0, 31);
      if (b == 0) begin
        eq = 32'hFFFFFFFF; er = a; edz = 1'b1;
      end else if (a == 32'sh80000000 && b == -1) begin
        eq = 32'h80000000; er = 0; edz = 1'b0;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0;
      end
      run_op(a, b, q, r, dz, lat, bc);
      checks++;
      if (q !== eq || r !== er || dz !== edz || lat !== ((b == 0) ? 1 : 33)) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b",
                 n, a, b, q, r, dz, lat, eq, er, edz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_extremes();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
